// File: rtl/vram_pkg.sv
// vram_pkg: shared geometry, command and clear-state encodings for vram_sched
package vram_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam logic [AW-1:0] CELLS_A = AW'(CELLS);
  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);
  localparam logic [DW-1:0] BLANK = 12'h020;
  typedef enum logic [1:0] {
    CMD_WRITE_AT   = 2'b00,
    CMD_WRITE_NEXT = 2'b01,
    CMD_SET_CURSOR = 2'b10,
    CMD_NOP        = 2'b11
  } cmd_t;
  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;
endpackage

// File: rtl/vram_clr_fsm.sv
// vram_clr_fsm: screen-clear walker, one BLANK write per cycle not taken by scan
module vram_clr_fsm
  import vram_pkg::*;
(
  input  logic          pclk,
  input  logic          reset,
  input  logic          start,
  input  logic          scan,
  output logic          busy,
  output logic [AW-1:0] cnt,
  output logic          done
);
  clr_state_t state;
  assign busy = state == CLR_RUN;
  assign done = busy & ~scan & (cnt == LAST);
  always_ff @(posedge pclk) begin
    if (reset) begin
      state <= CLR_IDLE;
      cnt <= '0;
    end else if (state == CLR_IDLE) begin
      if (start) begin
        state <= CLR_RUN;
        cnt <= '0;
      end
    end else if (!scan) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= CLR_IDLE;
    end
  end
endmodule

// File: rtl/vram_sched.sv
// vram_sched: VRAM arbiter, scan > clear > writer; clear engine built with VRAM_CLEAR_EN
module vram_sched
  import vram_pkg::*;
(
  input  logic          pclk,
  input  logic          reset,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data,
  output logic          scan_dvalid,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [1:0]    wr_cmd,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [AW-1:0] cursor,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  logic scan_hit, acc, wr_we, clr_done, scan_q, hit_q;
  logic [AW-1:0] clr_cnt, wr_at;
`ifdef VRAM_CLEAR_EN
  vram_clr_fsm u_clr (
    .pclk(pclk), .reset(reset), .start(clr_start), .scan(scan_hit),
    .busy(clr_busy), .cnt(clr_cnt), .done(clr_done)
  );
`else
  logic unused_clr;
  assign unused_clr = clr_start;
  assign clr_busy = 1'b0;
  assign clr_cnt = '0;
  assign clr_done = 1'b0;
`endif
  assign scan_hit = scan_req & (scan_addr < CELLS_A);
  assign wr_ready = ~clr_busy & ~scan_hit;
  assign acc = wr_valid & wr_ready;
  assign wr_at = (wr_cmd == CMD_WRITE_NEXT) ? cursor : wr_addr;
  assign wr_we = (wr_cmd == CMD_WRITE_NEXT) | ((wr_cmd == CMD_WRITE_AT) & (wr_addr < CELLS_A));
  assign ram_addr = scan_hit ? scan_addr : clr_busy ? clr_cnt : wr_at;
  assign ram_we = ~reset & ~scan_hit & (clr_busy | (acc & wr_we));
  assign ram_wdata = clr_busy ? BLANK : wr_data;
  always_ff @(posedge pclk) begin
    if (reset) cursor <= '0;
    else if (clr_done) cursor <= '0;
    else if (acc & (wr_cmd == CMD_WRITE_NEXT)) cursor <= (cursor == LAST) ? '0 : cursor + 1'b1;
    else if (acc & (wr_cmd == CMD_SET_CURSOR) & (wr_addr < CELLS_A)) cursor <= wr_addr;
  end
  // out-of-range scans skip the RAM but still return BLANK on the normal schedule
  always_ff @(posedge pclk) begin
    if (reset) begin
      scan_q <= 1'b0;
      hit_q <= 1'b0;
      scan_dvalid <= 1'b0;
      scan_data <= '0;
    end else begin
      scan_q <= scan_req;
      hit_q <= scan_hit;
      scan_dvalid <= scan_q;
      if (scan_q) scan_data <= hit_q ? ram_rdata : BLANK;
    end
  end
endmodule
